psimd_issue_ctrl: RTL and testbench

Parametrised single-issue controller for the PSIMD DLFloat16 datapath: accepts one 32-bit instruction at a time over a valid/ready handshake, owns the vector register file, sequences multi-cycle execution-unit operations and handshaked memory loads/stores, and writes results back. Successor to the fixed 4-lane, purely combinational PSIMD top. Lane count, register count and watchdog depth are parameters, and EU and memory latency are arbitrary. Sits between the scalar core (instruction, rs1 value) and the external Execution_unit and memory.

---
 rtl/psimd_pkg.sv | 31 +++
 rtl/psimd_regfile.sv | 39 +++
 rtl/psimd_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_psimd_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psimd_pkg.sv
// Shared PSIMD constants: opcodes, controller states, FP flag bit positions
// and the DLFloat16 element width.
package psimd_pkg;

  localparam int unsigned ELEM_WIDTH = 16;
  localparam int unsigned FLAG_WIDTH = 5;

  // Per-lane flag vector is {invalid, inexact, overflow, underflow, div_by_zero}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_NX = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_DZ = 0;

  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;
  localparam logic [6:0] OPC_OP    = 7'b1010011;
  localparam logic [6:0] OPC_FMA   = 7'b1000011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/psimd_regfile.sv
// Vector register file: three combinational read ports, one synchronous
// write port, synchronous active-high clear of every entry.
module psimd_regfile
  import psimd_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_WIDTH = 64,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     raddr1_i,
  input  logic [IDX_W-1:0]     raddr2_i,
  input  logic [IDX_W-1:0]     raddr3_i,
  output logic [REG_WIDTH-1:0] rdata1_o,
  output logic [REG_WIDTH-1:0] rdata2_o,
  output logic [REG_WIDTH-1:0] rdata3_o,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [REG_WIDTH-1:0] wdata_i
);

  logic [REG_WIDTH-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = rf_q[raddr1_i];
  assign rdata2_o = rf_q[raddr2_i];
  assign rdata3_o = rf_q[raddr3_i];

endmodule

// File: rtl/psimd_issue_ctrl.sv
// Single-issue PSIMD controller: IDLE -> EXEC/MEM -> WB with watchdog abort.
// Sticky FP flag accumulation is built only when PSIMD_FLAGS_EN is defined.
module psimd_issue_ctrl
  import psimd_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned REG_WIDTH = ELEM_WIDTH * LANES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_valid_i,
  input  logic [31:0]                 instr_i,
  input  logic [31:0]                 rs1_core_i,
  output logic                        instr_ready_o,
  output logic                        eu_start_o,
  output logic [31:0]                 eu_instr_o,
  output logic [REG_WIDTH-1:0]        eu_src1_o,
  output logic [REG_WIDTH-1:0]        eu_src2_o,
  output logic [REG_WIDTH-1:0]        eu_src3_o,
  input  logic                        eu_done_i,
  input  logic [REG_WIDTH-1:0]        eu_result_i,
  input  logic [FLAG_WIDTH*LANES-1:0] eu_flags_i,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [31:0]                 mem_addr_o,
  output logic [REG_WIDTH-1:0]        mem_wdata_o,
  input  logic                        mem_ack_i,
  input  logic [REG_WIDTH-1:0]        mem_rdata_i,
  output logic                        done_o,
  output logic                        illegal_o,
  output logic                        timeout_err_o,
  input  logic                        flags_clr_i,
  output logic [FLAG_WIDTH-1:0]       fflags_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic [REG_WIDTH-1:0] src1_q, src1_d, src2_q, src2_d, src3_q, src3_d;
  logic [REG_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                 wb_we_q, wb_we_d;
  logic                 eu_start_q, eu_start_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;

  logic [6:0]           opc_c;
  logic [31:0]          ld_imm_c, st_imm_c;
  logic                 wd_expired_c;
  logic [REG_WIDTH-1:0] rf_rd1_c, rf_rd2_c, rf_rd3_c;
  logic                 rf_we_c;

  assign opc_c        = instr_i[6:0];
  assign ld_imm_c     = sext12(instr_i[31:20]);
  assign st_imm_c     = sext12({instr_i[31:25], instr_i[11:7]});
  assign wd_expired_c = (wd_cnt_q == WD_W'(TIMEOUT));
  assign rf_we_c      = (state_q == ST_WB) && wb_we_q;

  psimd_regfile #(
    .NUM_REGS  (NUM_REGS),
    .REG_WIDTH (REG_WIDTH)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .raddr1_i (instr_i[15 +: IDX_W]),
    .raddr2_i (instr_i[20 +: IDX_W]),
    .raddr3_i (instr_i[27 +: IDX_W]),
    .rdata1_o (rf_rd1_c),
    .rdata2_o (rf_rd2_c),
    .rdata3_o (rf_rd3_c),
    .we_i     (rf_we_c),
    .waddr_i  (instr_q[7 +: IDX_W]),
    .wdata_i  (wb_data_q)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    src3_d     = src3_q;
    wb_data_d  = wb_data_q;
    wb_we_d    = wb_we_q;
    eu_start_d = 1'b0;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    wd_cnt_d   = wd_cnt_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid_i) begin
          instr_d  = instr_i;
          src1_d   = rf_rd1_c;
          src2_d   = rf_rd2_c;
          src3_d   = rf_rd3_c;
          wd_cnt_d = '0;
          case (opc_c)
            OPC_OP, OPC_FMA: begin
              state_d    = ST_EXEC;
              eu_start_d = 1'b1;
              wb_we_d    = 1'b1;
            end
            OPC_LOAD: begin
              state_d    = ST_MEM;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = rs1_core_i + ld_imm_c;
              wb_we_d    = 1'b1;
            end
            OPC_STORE: begin
              state_d    = ST_MEM;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b1;
              mem_addr_d = rs1_core_i + st_imm_c;
              wb_we_d    = 1'b0;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      // A completion in the expiry cycle still retires normally
      ST_EXEC: begin
        if (eu_done_i) begin
          wb_data_d = eu_result_i;
          done_d    = 1'b1;
          state_d   = ST_WB;
        end else if (wd_expired_c) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      ST_MEM: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            wb_data_d = mem_rdata_i;
          end
          done_d  = 1'b1;
          state_d = ST_WB;
        end else if (wd_expired_c) begin
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      src3_q     <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      eu_start_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wd_cnt_q   <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      src3_q     <= src3_d;
      wb_data_q  <= wb_data_d;
      wb_we_q    <= wb_we_d;
      eu_start_q <= eu_start_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wd_cnt_q   <= wd_cnt_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef PSIMD_FLAGS_EN
  logic [FLAG_WIDTH-1:0] fflags_q, fflags_d, lane_or_c;
  logic                  flag_cap_c;

  // A clear coinciding with a capture keeps only the new flags
  always_comb begin
    lane_or_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_or_c = lane_or_c | eu_flags_i[FLAG_WIDTH*l +: FLAG_WIDTH];
    end
    flag_cap_c = (state_q == ST_EXEC) && eu_done_i;
    fflags_d   = fflags_q;
    if (flags_clr_i) begin
      fflags_d = flag_cap_c ? lane_or_c : '0;
    end else if (flag_cap_c) begin
      fflags_d = fflags_q | lane_or_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{flags_clr_i, eu_flags_i};
  assign fflags_o           = '0;
`endif

  assign instr_ready_o = (state_q == ST_IDLE);
  assign eu_start_o    = eu_start_q;
  assign eu_instr_o    = instr_q;
  assign eu_src1_o     = src1_q;
  assign eu_src2_o     = src2_q;
  assign eu_src3_o     = src3_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = src2_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_psimd_issue_ctrl.sv
// Randomized bench for psimd_issue_ctrl against a transaction-level model of
// the register file and sticky flags; honours PSIMD_FLAGS_EN when defined.
module tb_psimd_issue_ctrl;
  import psimd_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned NREG  = 32;
  localparam int unsigned TMO   = 8;
  localparam int unsigned RW    = 16 * LANES;

  logic              clk, rst;
  logic              instr_valid;
  logic [31:0]       instr, rs1_core;
  logic              instr_ready, eu_start;
  logic [31:0]       eu_instr;
  logic [RW-1:0]     eu_src1, eu_src2, eu_src3;
  logic              eu_done;
  logic [RW-1:0]     eu_result;
  logic [5*LANES-1:0] eu_flags;
  logic              mem_req, mem_we;
  logic [31:0]       mem_addr;
  logic [RW-1:0]     mem_wdata;
  logic              mem_ack;
  logic [RW-1:0]     mem_rdata;
  logic              done, illegal, timeout_err, flags_clr;
  logic [4:0]        fflags;

  psimd_issue_ctrl #(.LANES(LANES), .NUM_REGS(NREG), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(instr_valid), .instr_i(instr), .rs1_core_i(rs1_core),
    .instr_ready_o(instr_ready),
    .eu_start_o(eu_start), .eu_instr_o(eu_instr),
    .eu_src1_o(eu_src1), .eu_src2_o(eu_src2), .eu_src3_o(eu_src3),
    .eu_done_i(eu_done), .eu_result_i(eu_result), .eu_flags_i(eu_flags),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .done_o(done), .illegal_o(illegal), .timeout_err_o(timeout_err),
    .flags_clr_i(flags_clr), .fflags_o(fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] rf_m [NREG];
  logic [4:0]    flags_m;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] lanes_or(input logic [5*LANES-1:0] f);
    logic [4:0] r = '0;
    for (int l = 0; l < int'(LANES); l++) r = r | f[5*l +: 5];
    return r;
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, 2'b00, b, a, 3'b000, rd, opc};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) rf_m[i] = '0;
    flags_m = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_eu_start", eu_start, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_eu_instr", eu_instr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pulses", {illegal, timeout_err}, 0);
    check("rst_fflags", fflags, 0);
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] base);
    check("ready_before_issue", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = w;
    rs1_core    = base;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom;
    rs1_core    = $urandom;
  endtask

  task automatic do_op(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input bit fma, input int lat,
                       input logic [RW-1:0] res, input logic [5*LANES-1:0] fl, input bit clr);
    logic [31:0] w;
    logic [4:0]  newf;
    int starts = 0;
    w = mk_r(fma ? OPC_FMA : OPC_OP, rd, a, b, c);
    issue(w, $urandom);
    for (int cyc = 0; cyc <= lat; cyc++) begin
      if (cyc == 0) begin
        check("op_eu_instr", eu_instr, w);
        check("op_src1", eu_src1, rf_m[a]);
        check("op_src2", eu_src2, rf_m[b]);
        check("op_src3", eu_src3, rf_m[c]);
      end
      if (eu_start) starts++;
      check("op_no_early_done", done, 0);
      if (cyc == lat) begin
        eu_done   = 1'b1;
        eu_result = res;
        eu_flags  = fl;
        flags_clr = clr;
      end
      @(negedge clk);
      eu_done   = 1'b0;
      eu_result = {$urandom, $urandom};
      eu_flags  = 20'($urandom);
      flags_clr = 1'b0;
    end
    check("op_start_pulses", starts, 1);
    check("op_done", done, 1);
    rf_m[rd] = res;
    newf = lanes_or(fl);
`ifdef PSIMD_FLAGS_EN
    flags_m = clr ? newf : (flags_m | newf);
`else
    flags_m = newf & 5'b0;
`endif
    check("op_fflags", fflags, flags_m);
    @(negedge clk);
    check("op_done_pulse", done, 0);
    check("op_ready_after", instr_ready, 1);
  endtask

  task automatic do_mem(input bit st, input logic [4:0] r, input logic [4:0] a,
                        input logic [31:0] base, input int imm, input int lat,
                        input logic [RW-1:0] rdata);
    logic [11:0] i12;
    logic [31:0] w, exp_addr;
    i12 = 12'(imm);
    exp_addr = base + 32'(imm);
    if (st) w = {i12[11:5], r, a, 3'b010, i12[4:0], OPC_STORE};
    else    w = {i12, a, 3'b010, r, OPC_LOAD};
    issue(w, base);
    for (int cyc = 0; cyc <= lat; cyc++) begin
      check("mem_req_held", mem_req, 1);
      check("mem_we", mem_we, st);
      check("mem_addr", mem_addr, exp_addr);
      if (st) check("mem_wdata", mem_wdata, rf_m[r]);
      check("mem_no_eu_start", eu_start, 0);
      if (cyc == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
    end
    check("mem_req_dropped", mem_req, 0);
    check("mem_done", done, 1);
    if (!st) rf_m[r] = rdata;
    @(negedge clk);
    check("mem_ready_after", instr_ready, 1);
  endtask

  task automatic do_illegal();
    logic [6:0] opc;
    opc = 7'($urandom);
    while (opc == OPC_LOAD || opc == OPC_STORE || opc == OPC_OP || opc == OPC_FMA)
      opc = 7'($urandom);
    issue({25'($urandom), opc}, $urandom);
    check("ill_pulse", illegal, 1);
    check("ill_ready", instr_ready, 1);
    check("ill_quiet", {done, eu_start, mem_req}, 0);
    @(negedge clk);
    check("ill_pulse_end", illegal, 0);
  endtask

  task automatic do_timeout(input bit mem_kind);
    int hit = -1;
    if (mem_kind) issue({12'h010, 5'd1, 3'b010, 5'd9, OPC_LOAD}, 32'h40);
    else          issue(mk_r(OPC_OP, 5'd9, 5'd1, 5'd2, 5'd3), 32'h0);
    for (int cyc = 0; cyc < 20 && hit < 0; cyc++) begin
      if (timeout_err) hit = cyc;
      else begin
        if (done) check("tmo_no_done", done, 0);
        @(negedge clk);
      end
    end
    check(mem_kind ? "tmo_mem_cycle" : "tmo_exec_cycle", 64'(hit), 64'(9));
    check("tmo_ready", instr_ready, 1);
    check("tmo_req_drop", {mem_req, done}, 0);
    @(negedge clk);
    check("tmo_pulse_end", timeout_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog got=stuck exp=finish");
    $fatal(1);
  end

  initial begin
    logic [5*LANES-1:0] fl;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; rs1_core = '0;
    eu_done = 1'b0; eu_result = '0; eu_flags = '0;
    mem_ack = 1'b0; mem_rdata = '0; flags_clr = 1'b0;
    model_reset();
    reset_dut();

    // Directed: OP with 4-cycle EU latency, then read back via a store
    do_op(5'd3, 5'd1, 5'd2, 5'd4, 1'b0, 4, 64'h1234_5678_9ABC_DEF0, '0, 1'b0);
    do_mem(1'b1, 5'd3, 5'd0, 32'h0, 0, 0, '0);
    do_mem(1'b0, 5'd5, 5'd2, 32'h100, -8, 0, 64'hAAAA_AAAA_AAAA_AAAA);
    do_mem(1'b1, 5'd5, 5'd2, 32'h200, -1, 3, '0);
    do_op(5'd3, 5'd3, 5'd5, 5'd3, 1'b1, 0, 64'h0F0F_0F0F_0000_1111, '0, 1'b0);
    do_op(5'd6, 5'd3, 5'd3, 5'd3, 1'b0, int'(TMO), 64'hDEAD_BEEF_0000_0001, '0, 1'b0);
    do_illegal();
    do_mem(1'b1, 5'd3, 5'd0, 32'h0, 16, 1, '0);
    do_timeout(1'b0);
    do_timeout(1'b1);
    do_mem(1'b1, 5'd9, 5'd0, 32'h0, 0, 0, '0);

    // Directed flag sequence from a clean reset
    reset_dut();
    fl = '0; fl[5*2 + FLAG_OF] = 1'b1;
    do_op(5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1, 64'h1, fl, 1'b0);
    fl = '0; fl[5*0 + FLAG_NX] = 1'b1;
    do_op(5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 2, 64'h2, fl, 1'b0);
`ifdef PSIMD_FLAGS_EN
    check("flags_accum", fflags, 5'b01100);
`else
    check("flags_accum", fflags, 5'b00000);
`endif
    fl = '0; fl[5*1 + FLAG_NV] = 1'b1;
    do_op(5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 0, 64'h4, fl, 1'b1);
`ifdef PSIMD_FLAGS_EN
    check("flags_clr_cap", fflags, 5'b10000);
`else
    check("flags_clr_cap", fflags, 5'b00000);
`endif

    // Reset while a load waits for its ack
    do_mem(1'b0, 5'd7, 5'd0, 32'h80, 4, 0, 64'h7777_0000_7777_0000);
    issue({12'h004, 5'd0, 3'b010, 5'd7, OPC_LOAD}, 32'h80);
    check("rstmem_req_before", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rstmem_req_after", mem_req, 0);
    check("rstmem_ready", instr_ready, 1);
    check("rstmem_done", done, 0);
    @(negedge clk);
    do_mem(1'b1, 5'd7, 5'd0, 32'h0, 0, 0, '0);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      int kind = int'($urandom_range(0, 9));
      logic [4:0] ra = 5'($urandom), rb = 5'($urandom), rc = 5'($urandom), rd = 5'($urandom);
      if (kind <= 3)
        do_op(rd, ra, rb, rc, kind[0], int'($urandom_range(0, TMO)), {$urandom, $urandom},
              20'($urandom) & 20'($urandom), ($urandom_range(0, 5) == 0));
      else if (kind <= 5)
        do_mem(1'b0, rd, ra, $urandom, int'($urandom_range(0, 4095)) - 2048,
               int'($urandom_range(0, 5)), {$urandom, $urandom});
      else if (kind <= 8)
        do_mem(1'b1, rb, ra, $urandom, int'($urandom_range(0, 4095)) - 2048,
               int'($urandom_range(0, 5)), '0);
      else
        do_illegal();
    end
    for (int r = 0; r < int'(NREG); r++) do_mem(1'b1, 5'(r), 5'd0, 32'h0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
